// File: rtl/matrix_sched.sv
// Frame scheduler in front of matrix_core: round-robin between two requesters,
// owns LED driver configuration (post-reset, on brightness change, periodic refresh).
`timescale 1ns/1ps
module matrix_sched #(
    parameter int REFRESH_CYC = 900000,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk_9m,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [63:0] din0 [7:0],
    input  logic [63:0] din1 [7:0],
    input  logic [3:0]  intensity,
    output logic [1:0]  gnt,
    output logic        core_en,
    output logic [63:0] core_din [7:0],
    input  logic        core_send_done,
    output logic        busy,
    output logic        err
);

    localparam int RW = (REFRESH_CYC > 0) ? $clog2(REFRESH_CYC + 1) : 1;
    localparam int WW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {CFG_LOAD, SEND, WAIT, IDLE} state_t;

    state_t        state, state_nxt;
    logic          rr_ptr, rr_ptr_nxt;
    logic          cfg_pend, cfg_pend_nxt;
    logic [3:0]    last_int, last_int_nxt;
    logic [RW-1:0] refresh_cnt, refresh_cnt_nxt;
    logic [WW-1:0] wdog, wdog_nxt;
    logic [1:0]    gnt_nxt;
    logic          core_en_nxt;
    logic          err_nxt;
    logic          pick1;
    logic [63:0]   din_nxt [7:0];
    logic [63:0]   cfg_frame [7:0];

    assign busy = (state != IDLE);

    // Each row is one 16-bit register write, replicated once per cascaded chip.
    always_comb begin
        cfg_frame[0] = {4{16'h0C01}};
        cfg_frame[1] = {4{16'h0900}};
        cfg_frame[2] = {4{12'h0A0, intensity}};
        cfg_frame[3] = {4{16'h0B07}};
        cfg_frame[4] = {4{16'h0F00}};
        cfg_frame[5] = '0;
        cfg_frame[6] = '0;
        cfg_frame[7] = '0;
    end

    // rr_ptr remembers the last requester granted; the other one wins a tie.
    assign pick1 = req[1] && (!req[0] || !rr_ptr);

    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        cfg_pend_nxt    = cfg_pend;
        last_int_nxt    = last_int;
        refresh_cnt_nxt = refresh_cnt;
        wdog_nxt        = wdog;
        gnt_nxt         = 2'b00;
        core_en_nxt     = 1'b0;
        err_nxt         = err;
        din_nxt         = core_din;

        // A refresh expiry only raises cfg_pend, so a request seen this cycle still wins.
        if (state == IDLE && REFRESH_CYC > 0) begin
            if (refresh_cnt == RW'(REFRESH_CYC - 1)) begin
                refresh_cnt_nxt = '0;
                cfg_pend_nxt    = 1'b1;
            end else begin
                refresh_cnt_nxt = refresh_cnt + 1'b1;
            end
        end

        case (state)
            CFG_LOAD: begin
                din_nxt      = cfg_frame;
                last_int_nxt = intensity;
                cfg_pend_nxt = 1'b0;
                state_nxt    = SEND;
            end
            SEND: begin
                core_en_nxt = 1'b1;
                wdog_nxt    = '0;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (core_send_done) begin
                    refresh_cnt_nxt = '0;
                    state_nxt       = IDLE;
                end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
                    err_nxt      = 1'b1;
                    cfg_pend_nxt = 1'b1;
                    wdog_nxt     = '0;
                    state_nxt    = IDLE;
                end else begin
                    wdog_nxt = wdog + 1'b1;
                end
            end
            IDLE: begin
                if (cfg_pend || intensity != last_int) begin
                    state_nxt = CFG_LOAD;
                end else if (req != 2'b00) begin
                    if (pick1) begin
                        din_nxt = din1;
                        gnt_nxt = 2'b10;
                    end else begin
                        din_nxt = din0;
                        gnt_nxt = 2'b01;
                    end
                    rr_ptr_nxt = pick1;
                    state_nxt  = SEND;
                end
            end
            default: state_nxt = CFG_LOAD;
        endcase
    end

    always_ff @(posedge clk_9m or posedge rst) begin
        if (rst) begin
            state       <= CFG_LOAD;
            rr_ptr      <= 1'b0;
            cfg_pend    <= 1'b1;
            last_int    <= 4'h0;
            refresh_cnt <= '0;
            wdog        <= '0;
            gnt         <= 2'b00;
            core_en     <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < 8; i++) core_din[i] <= '0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            cfg_pend    <= cfg_pend_nxt;
            last_int    <= last_int_nxt;
            refresh_cnt <= refresh_cnt_nxt;
            wdog        <= wdog_nxt;
            gnt         <= gnt_nxt;
            core_en     <= core_en_nxt;
            err         <= err_nxt;
            core_din    <= din_nxt;
        end
    end

endmodule

// File: tb/tb_matrix_sched.sv
// Bench for matrix_sched: expected frames are queued as stimulus is driven and
// compared at every core_en; grant order, watchdog, refresh and reset timing checked too.
`timescale 1ns/1ps
module tb_matrix_sched;

    localparam int REFRESH    = 60;
    localparam int TIMEOUT    = 100;
    localparam int DONE_DELAY = 20;

    typedef logic [7:0][63:0] frame_t;
    typedef struct packed { logic [1:0] src; frame_t frame; } exp_t;
    typedef struct packed { logic [3:0] intensity; logic [63:0] exp_row2; } int_vec_t;

    logic        clk_9m = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [63:0] din0 [7:0];
    logic [63:0] din1 [7:0];
    logic [3:0]  intensity;
    logic [1:0]  gnt;
    logic        core_en;
    logic [63:0] core_din [7:0];
    logic        core_send_done;
    logic        busy;
    logic        err;

    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;
    int     done_cyc = 0;
    bit     auto_done;
    exp_t   sb_q[$];
    frame_t f0, f1;
    int_vec_t   int_tbl [4];
    logic [1:0] rr_tbl [4];

    matrix_sched #(.REFRESH_CYC(REFRESH), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_9m(clk_9m), .rst(rst), .req(req), .din0(din0), .din1(din1),
        .intensity(intensity), .gnt(gnt), .core_en(core_en), .core_din(core_din),
        .core_send_done(core_send_done), .busy(busy), .err(err)
    );

    always #5 clk_9m = ~clk_9m;
    always @(posedge clk_9m) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [3:0] i);
        req       = r;
        intensity = i;
    endtask

    function automatic frame_t cfg_frame(input logic [3:0] v);
        frame_t f = '0;
        f[0] = {4{16'h0C01}};
        f[1] = {4{16'h0900}};
        f[2] = {4{12'h0A0, v}};
        f[3] = {4{16'h0B07}};
        f[4] = {4{16'h0F00}};
        return f;
    endfunction

    function automatic frame_t dut_frame();
        frame_t f;
        for (int i = 0; i < 8; i++) f[i] = core_din[i];
        return f;
    endfunction

    task automatic pushExpect(input logic [1:0] src, input frame_t frame);
        exp_t e;
        e.src   = src;
        e.frame = frame;
        sb_q.push_back(e);
    endtask

    task automatic waitCoreEn(input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_9m);
            if (core_en) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            $display("[TB] FAIL %s: no core_en within %0d cycles", name, budget);
        end
    endtask

    task automatic waitGnt(input int budget, output int at, output logic [1:0] g);
        at = -1;
        g  = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_9m);
            if (gnt != 2'b00) begin
                at = cyc;
                g  = gnt;
                break;
            end
        end
        if (at < 0) begin
            checks++;
            $display("[TB] FAIL grant wait: no gnt within %0d cycles", budget);
        end
    endtask

    task automatic waitIdle(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_9m);
            if (!busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            $display("[TB] FAIL idle wait: busy still 1 after %0d cycles", budget);
        end
    endtask

    // Scoreboard: every core_en must match the oldest queued frame and its grant source.
    initial begin
        logic [1:0] pend_gnt;
        exp_t e;
        pend_gnt = 2'b00;
        forever begin
            @(negedge clk_9m);
            if (!rst) begin
                if (gnt != 2'b00) pend_gnt = gnt;
                if (core_en) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected core_en: got a transfer, expected none queued");
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("frame source", pend_gnt, e.src);
                        checkOutput("frame data", dut_frame(), e.frame);
                    end
                    pend_gnt = 2'b00;
                end
            end
        end
    end

    // Core model: answers each core_en with send_done DONE_DELAY cycles later when enabled.
    initial begin
        core_send_done = 1'b0;
        forever begin
            @(negedge clk_9m);
            if (core_en && auto_done && !rst) begin
                repeat (DONE_DELAY - 1) @(negedge clk_9m);
                core_send_done = 1'b1;
                done_cyc = cyc;
                @(negedge clk_9m);
                core_send_done = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global timeout: simulation did not finish");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int t_rel, t_en, t_g, t_prev, t_cfg;
        logic [1:0] g;

        int_tbl[0] = '{intensity: 4'hF, exp_row2: 64'h0A0F0A0F0A0F0A0F};
        int_tbl[1] = '{intensity: 4'h0, exp_row2: 64'h0A000A000A000A00};
        int_tbl[2] = '{intensity: 4'hA, exp_row2: 64'h0A0A0A0A0A0A0A0A};
        int_tbl[3] = '{intensity: 4'h5, exp_row2: 64'h0A050A050A050A05};
        rr_tbl[0] = 2'b10;
        rr_tbl[1] = 2'b01;
        rr_tbl[2] = 2'b10;
        rr_tbl[3] = 2'b01;

        for (int i = 0; i < 8; i++) begin
            f0[i] = {$urandom, $urandom};
            f1[i] = {$urandom, $urandom};
            din0[i] = f0[i];
            din1[i] = f1[i];
        end

        rst = 1'b1;
        auto_done = 1'b1;
        applyStimulus(2'b00, 4'h5);
        repeat (3) @(negedge clk_9m);
        checkOutput("reset gnt", gnt, 2'b00);
        checkOutput("reset core_en", core_en, 1'b0);
        checkOutput("reset busy", busy, 1'b1);
        checkOutput("reset err", err, 1'b0);
        checkOutput("reset core_din", dut_frame(), '0);

        pushExpect(2'b00, cfg_frame(4'h5));
        rst = 1'b0;
        t_rel = cyc;
        waitCoreEn(10, "first config", t_en);
        checkOutput("release-to-core_en", t_en - t_rel, 2);
        checkOutput("config row0", core_din[0], 64'h0C010C010C010C01);
        checkOutput("config row2", core_din[2], 64'h0A050A050A050A05);
        while (cyc < t_en + DONE_DELAY - 1) @(negedge clk_9m);
        checkOutput("busy before done", busy, 1'b1);
        @(negedge clk_9m);
        checkOutput("busy after done", busy, 1'b0);

        for (int k = 0; k < 4; k++) begin
            pushExpect(2'b00, cfg_frame(int_tbl[k].intensity));
            applyStimulus(2'b00, int_tbl[k].intensity);
            waitCoreEn(10, "intensity config", t_en);
            checkOutput($sformatf("intensity %0h row2", int_tbl[k].intensity), core_din[2], int_tbl[k].exp_row2);
            waitIdle(40);
        end

        pushExpect(2'b10, f1);
        pushExpect(2'b01, f0);
        pushExpect(2'b10, f1);
        pushExpect(2'b01, f0);
        applyStimulus(2'b11, 4'h5);
        t_prev = cyc;
        for (int k = 0; k < 4; k++) begin
            waitGnt(60, t_g, g);
            checkOutput($sformatf("rr gnt %0d", k), g, rr_tbl[k]);
            if (k == 0) checkOutput("req-to-gnt latency", t_g - t_prev, 1);
            else checkOutput($sformatf("grant spacing %0d", k), t_g - t_prev, DONE_DELAY + 2);
            t_prev = t_g;
        end
        applyStimulus(2'b00, 4'h5);
        waitIdle(40);

        pushExpect(2'b01, f0);
        applyStimulus(2'b01, 4'h5);
        waitGnt(10, t_g, g);
        checkOutput("req0 gnt", g, 2'b01);
        applyStimulus(2'b00, 4'h5);
        waitCoreEn(5, "req0 transfer", t_en);
        repeat (5) @(negedge clk_9m);
        pushExpect(2'b00, cfg_frame(4'hF));
        pushExpect(2'b10, f1);
        applyStimulus(2'b10, 4'hF);
        repeat (2) @(negedge clk_9m);
        checkOutput("core_din held in WAIT", core_din[2], f0[2]);
        waitCoreEn(40, "config after intensity change", t_en);
        checkOutput("row2 after change", core_din[2], 64'h0A0F0A0F0A0F0A0F);
        waitGnt(40, t_g, g);
        checkOutput("deferred req1 gnt", g, 2'b10);
        applyStimulus(2'b00, 4'hF);
        waitIdle(60);

        auto_done = 1'b0;
        pushExpect(2'b01, f0);
        applyStimulus(2'b01, 4'hF);
        waitGnt(10, t_g, g);
        applyStimulus(2'b00, 4'hF);
        waitCoreEn(5, "transfer before timeout", t_en);
        pushExpect(2'b00, cfg_frame(4'hF));
        while (cyc < t_en + TIMEOUT - 1) @(negedge clk_9m);
        checkOutput("err before timeout", err, 1'b0);
        @(negedge clk_9m);
        checkOutput("err at timeout", err, 1'b1);
        auto_done = 1'b1;
        waitCoreEn(10, "config after timeout", t_cfg);
        checkOutput("timeout-to-config", t_cfg - t_en, TIMEOUT + 3);
        waitIdle(40);
        checkOutput("err sticky", err, 1'b1);

        for (int k = 0; k < 2; k++) begin
            pushExpect(2'b00, cfg_frame(4'hF));
            t_prev = done_cyc;
            waitCoreEn(REFRESH + 40, "refresh config", t_en);
            checkOutput($sformatf("refresh interval %0d", k), t_en - t_prev, REFRESH + 4);
            waitIdle(40);
        end

        auto_done = 1'b0;
        pushExpect(2'b01, f0);
        applyStimulus(2'b01, 4'hF);
        waitGnt(10, t_g, g);
        applyStimulus(2'b00, 4'hF);
        waitCoreEn(5, "transfer before reset", t_en);
        repeat (10) @(negedge clk_9m);
        rst = 1'b1;
        @(negedge clk_9m);
        checkOutput("mid-reset gnt", gnt, 2'b00);
        checkOutput("mid-reset core_en", core_en, 1'b0);
        checkOutput("mid-reset err", err, 1'b0);
        checkOutput("mid-reset busy", busy, 1'b1);
        checkOutput("mid-reset core_din", dut_frame(), '0);
        pushExpect(2'b00, cfg_frame(4'hF));
        auto_done = 1'b1;
        rst = 1'b0;
        t_rel = cyc;
        waitCoreEn(10, "config after reset", t_en);
        checkOutput("re-release-to-core_en", t_en - t_rel, 2);
        waitIdle(40);

        checkOutput("scoreboard drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
